// File: rtl/grid_pos_bcd_display.sv
// grid_pos_bcd_display: double-dabble BCD conversion of grid X/Y, time-multiplexed onto the board LEDs.
// Build option GRID_DISP_DEFER_EN: a change seen while showing waits for the hold counter to wrap.
module grid_pos_bcd_display #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int W           = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] final_x,
  input  logic [W-1:0] final_y,
  output logic [11:0]  bcd_x,
  output logic [11:0]  bcd_y,
  output logic         valid,
  output logic         busy,
  output logic [7:0]   led,
  output logic         led_hund,
  output logic         led_axis
);

  // state  | meaning
  // IDLE   | no conversion committed yet, waiting for a start
  // CONV_X | shifting snap_x through the BCD scratch, one bit per cycle
  // CONV_Y | same for snap_y
  // COMMIT | publish both results, restart display on X
  // SHOW   | alternate X/Y on the LEDs every HOLD_CYCLES
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV_X = 3'd1,
    CONV_Y = 3'd2,
    COMMIT = 3'd3,
    SHOW   = 3'd4
  } state_t;

  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(W - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  snap_x_q, snap_x_d;
  logic [W-1:0]  snap_y_q, snap_y_d;
  logic          pending_q, pending_d;
  logic [W-1:0]  bin_q, bin_d;
  logic [11:0]   scr_q, scr_d;
  logic [2:0]    bit_q, bit_d;
  logic [11:0]   res_x_q, res_x_d;
  logic [11:0]   bcd_x_q, bcd_x_d;
  logic [11:0]   bcd_y_q, bcd_y_d;
  logic          valid_q, valid_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          axis_q, axis_d;
  logic [7:0]    led_q, led_d;
  logic          led_hund_q, led_hund_d;
`ifdef GRID_DISP_DEFER_EN
  logic          defer_q, defer_d;
`endif

  logic          diff;
  logic          wrap;
  logic          start;
  logic [11:0]   scr_adj;
  logic [11:0]   scr_step;

  function automatic logic [11:0] dd_adj(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign diff     = {final_x, final_y} != {snap_x_q, snap_y_q};
  assign wrap     = (hold_q == HOLD_LAST);
  assign scr_adj  = dd_adj(scr_q);
  assign scr_step = (scr_adj << 1) | {11'd0, bin_q[W-1]};

  always_comb begin
    state_d    = state_q;
    snap_x_d   = snap_x_q;
    snap_y_d   = snap_y_q;
    pending_d  = pending_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    bit_d      = bit_q;
    res_x_d    = res_x_q;
    bcd_x_d    = bcd_x_q;
    bcd_y_d    = bcd_y_q;
    valid_d    = valid_q;
    hold_d     = hold_q;
    axis_d     = axis_q;
    led_d      = led_q;
    led_hund_d = led_hund_q;
    start      = 1'b0;
`ifdef GRID_DISP_DEFER_EN
    defer_d    = defer_q;
`endif

    case (state_q)
      IDLE: begin
        start = pending_q || diff;
      end

      CONV_X: begin
        scr_d = scr_step;
        bin_d = bin_q << 1;
        if (bit_q == 3'd0) begin
          res_x_d = scr_step;
          bin_d   = snap_y_q;
          scr_d   = '0;
          bit_d   = BIT_LAST;
          state_d = CONV_Y;
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end

      CONV_Y: begin
        scr_d = scr_step;
        bin_d = bin_q << 1;
        if (bit_q == 3'd0) begin
          state_d = COMMIT;
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end

      COMMIT: begin
        bcd_x_d    = res_x_q;
        bcd_y_d    = scr_q;
        valid_d    = 1'b1;
        axis_d     = 1'b0;
        hold_d     = '0;
        led_d      = res_x_q[7:0];
        led_hund_d = res_x_q[8];
        if (diff) pending_d = 1'b1;
        state_d    = SHOW;
      end

      SHOW: begin
        if (wrap) begin
          hold_d = '0;
          axis_d = ~axis_q;
        end else begin
          hold_d = hold_q + 1'b1;
        end
        led_d      = axis_d ? bcd_y_q[7:0] : bcd_x_q[7:0];
        led_hund_d = axis_d ? bcd_y_q[8]   : bcd_x_q[8];
`ifdef GRID_DISP_DEFER_EN
        // a change seen here only waits for the current axis to finish its hold
        start = pending_q || (wrap && (defer_q || diff));
        if (!start && diff) defer_d = 1'b1;
`else
        start = pending_q || diff;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      snap_x_d  = final_x;
      snap_y_d  = final_y;
      pending_d = 1'b0;
      bin_d     = final_x;
      scr_d     = '0;
      bit_d     = BIT_LAST;
      state_d   = CONV_X;
`ifdef GRID_DISP_DEFER_EN
      defer_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      pending_q  <= 1'b1;
      bin_q      <= '0;
      scr_q      <= '0;
      bit_q      <= '0;
      res_x_q    <= '0;
      bcd_x_q    <= '0;
      bcd_y_q    <= '0;
      valid_q    <= 1'b0;
      hold_q     <= '0;
      axis_q     <= 1'b0;
      led_q      <= '0;
      led_hund_q <= 1'b0;
`ifdef GRID_DISP_DEFER_EN
      defer_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      snap_x_q   <= snap_x_d;
      snap_y_q   <= snap_y_d;
      pending_q  <= pending_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      bit_q      <= bit_d;
      res_x_q    <= res_x_d;
      bcd_x_q    <= bcd_x_d;
      bcd_y_q    <= bcd_y_d;
      valid_q    <= valid_d;
      hold_q     <= hold_d;
      axis_q     <= axis_d;
      led_q      <= led_d;
      led_hund_q <= led_hund_d;
`ifdef GRID_DISP_DEFER_EN
      defer_q    <= defer_d;
`endif
    end
  end

  assign bcd_x    = bcd_x_q;
  assign bcd_y    = bcd_y_q;
  assign valid    = valid_q;
  assign busy     = (state_q == CONV_X) || (state_q == CONV_Y);
  assign led      = led_q;
  assign led_hund = led_hund_q;
  assign led_axis = axis_q;

endmodule

// File: tb/tb_grid_pos_bcd_display.sv
// Bench for grid_pos_bcd_display: directed scenarios plus random position changes and resets,
// compared every cycle against a cycle-count reference model using arithmetic BCD.
module tb_grid_pos_bcd_display;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst_n;
  logic [6:0]  final_x;
  logic [6:0]  final_y;
  logic [11:0] bcd_x;
  logic [11:0] bcd_y;
  logic        valid;
  logic        busy;
  logic [7:0]  led;
  logic        led_hund;
  logic        led_axis;

  int total = 0;
  int bad   = 0;

  grid_pos_bcd_display #(.HOLD_CYCLES(HOLD), .W(7)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .final_x  (final_x),
    .final_y  (final_y),
    .bcd_x    (bcd_x),
    .bcd_y    (bcd_y),
    .valid    (valid),
    .busy     (busy),
    .led      (led),
    .led_hund (led_hund),
    .led_axis (led_axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: m_t counts remaining edges of a conversion (15 = just started, 1 = commit cycle)
  int          m_t;
  logic [6:0]  m_sx, m_sy;
  bit          m_pend, m_defer, m_valid, m_show, m_axis, m_lh;
  logic [11:0] m_bx, m_by;
  int          m_hold;
  logic [7:0]  m_led;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_t = 0; m_sx = 0; m_sy = 0; m_pend = 1; m_defer = 0; m_valid = 0;
    m_show = 0; m_axis = 0; m_lh = 0; m_bx = 0; m_by = 0; m_hold = 0; m_led = 0;
  endtask

  task automatic model_step();
    bit diff, wrap, go;
    logic [11:0] cur;
    diff = (final_x != m_sx) || (final_y != m_sy);
    wrap = 0;
    go   = 0;
    if (m_t >= 2) begin
      m_t--;
    end else if (m_t == 1) begin
      m_t     = 0;
      m_bx    = to_bcd(int'(m_sx));
      m_by    = to_bcd(int'(m_sy));
      m_valid = 1;
      m_axis  = 0;
      m_hold  = 0;
      m_led   = m_bx[7:0];
      m_lh    = m_bx[8];
      m_show  = 1;
      if (diff) m_pend = 1;
    end else begin
      if (m_show) begin
        if (m_hold == HOLD - 1) begin
          m_hold = 0;
          m_axis = ~m_axis;
          wrap   = 1;
        end else begin
          m_hold++;
        end
        cur   = m_axis ? m_by : m_bx;
        m_led = cur[7:0];
        m_lh  = cur[8];
      end
`ifdef GRID_DISP_DEFER_EN
      if (!m_show) go = m_pend || diff;
      else begin
        go = m_pend || (wrap && (m_defer || diff));
        if (!go && diff) m_defer = 1;
      end
`else
      go = m_pend || diff;
`endif
      if (go) begin
        m_sx = final_x; m_sy = final_y;
        m_pend = 0; m_defer = 0;
        m_t = 15;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check("busy",     32'(busy),     32'(m_t >= 2));
    check("valid",    32'(valid),    32'(m_valid));
    check("bcd_x",    32'(bcd_x),    32'(m_bx));
    check("bcd_y",    32'(bcd_y),    32'(m_by));
    check("led",      32'(led),      32'(m_led));
    check("led_hund", 32'(led_hund), 32'(m_lh));
    check("led_axis", 32'(led_axis), 32'(m_axis));
  endtask

  // one clock: check at negedge, drive, model the next posedge
  task automatic cycle(input logic [6:0] x, input logic [6:0] y);
    @(negedge clk);
    check_all();
    rst_n   = 1'b1;
    final_x = x;
    final_y = y;
    @(posedge clk);
    model_step();
  endtask

  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
  endtask

  task automatic run(input int n, input logic [6:0] x, input logic [6:0] y);
    for (int i = 0; i < n; i++) cycle(x, y);
  endtask

  task automatic run_until_t(input int t, input logic [6:0] x, input logic [6:0] y);
    int n;
    n = 0;
    while (m_t != t && n < 100) begin
      cycle(x, y);
      n++;
    end
    if (m_t != t) check("wait_timeout", 32'(m_t), 32'(t));
  endtask

  int unsigned rx, ry;
  int          hi_busy;

  initial begin
    rst_n   = 1'b0;
    final_x = 7'd0;
    final_y = 7'd0;
    model_reset();
    #1;
    check_all();
    #22;

    // reset release at 0,0 always converts
    run(22, 7'd0, 7'd0);
    check("t1_valid", 32'(valid), 32'd1);

    // steady 127,5 with alternating display
    run(34, 7'd127, 7'd5);
    check("t2_bcd_x", 32'(bcd_x), 32'h127);
    check("t2_bcd_y", 32'(bcd_y), 32'h005);

    // x change during CONV_X
    run_until_t(15, 7'd10, 7'd5);
    run_until_t(11, 7'd10, 7'd5);
    run(40, 7'd99, 7'd5);
    check("t3_bcd_x", 32'(bcd_x), 32'h099);

    // reset during CONV_Y with x=64
    run_until_t(15, 7'd64, 7'd5);
    run_until_t(5, 7'd64, 7'd5);
    reset_pulse();
    run(25, 7'd64, 7'd5);
    check("t4_bcd_x", 32'(bcd_x), 32'h064);

    // boundary digits
    run(25, 7'd99, 7'd100);
    check("t5_bcd_y", 32'(bcd_y), 32'h100);

    // change one cycle into a hold period
    run(25, 7'd3, 7'd7);
    begin
      int n;
      n = 0;
      while (!(m_t == 0 && m_show && m_hold == 1) && n < 50) begin
        cycle(7'd3, 7'd7);
        n++;
      end
      if (!(m_t == 0 && m_show)) check("t6_wait", 32'(m_t), 32'd0);
    end
    run(30, 7'd4, 7'd7);

    // random stimulus
    rx = 0; ry = 0;
    hi_busy = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 3))
          0: rx = $urandom_range(0, 127);
          1: ry = $urandom_range(0, 127);
          2: rx = rx ^ (1 << $urandom_range(0, 6));
          default: begin rx = $urandom_range(0, 127); ry = $urandom_range(0, 127); end
        endcase
      end
      cycle(7'(rx), 7'(ry));
      if (busy) hi_busy++; else hi_busy = 0;
      if (hi_busy > 14) check("busy_len", 32'(hi_busy), 32'd14);
      if ($urandom_range(0, 499) == 0) reset_pulse();
    end

    @(negedge clk);
    check_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
